// File: rtl/irq_initiator.sv
// irq_initiator: initiator side of the ack/gnt/irq handshake.
// Upstream posts irq bits per channel; they accumulate in a pending register
// per channel. Channels are served round-robin, one ack->gnt handshake at a
// time, each bounded by a timeout after which the bits are queued again.
module irq_initiator #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evt_valid,
    input  logic [CH_W-1:0]       evt_ch,
    input  logic [7:0]            evt_irq,
    output logic                  evt_ready,
    output logic [NUM_CH-1:0]     ack_o,
    output logic [NUM_CH*8-1:0]   irq_o,
    input  logic [NUM_CH-1:0]     gnt_i,
    output logic                  done_valid,
    output logic [CH_W-1:0]       done_ch,
    output logic                  done_timeout,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       pending     [NUM_CH];
    logic [7:0]       pending_nxt [NUM_CH];
    logic [CH_W-1:0]  cur;
    logic [CH_W-1:0]  last;
    logic [7:0]       snap;
    logic [CNT_W-1:0] cnt;

    logic             sel_found;
    logic [CH_W-1:0]  sel_ch;
    logic [CH_W-1:0]  idx;
    logic             accept;
    logic             granted;
    logic             expired;

    assign accept  = evt_valid && evt_ready;
    // Grant takes priority over the timeout when both land in the same cycle.
    assign granted = (state == WAIT) && gnt_i[cur];
    assign expired = (state == WAIT) && !gnt_i[cur] && (cnt == CNT_W'(TIMEOUT - 1));

    // Round-robin pick: first non-empty channel after the last one served.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        // Scan from the farthest offset down so the nearest candidate is written last and wins.
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CH_W'((int'(last) + i) % NUM_CH);
            if (pending[idx] != 8'h00) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    // Next pending value: clear on selection, restore on timeout, then merge the
    // incoming event last so a same-cycle post to the selected channel survives.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pending_nxt[c] = pending[c];
            if (state == IDLE && sel_found && sel_ch == CH_W'(c)) begin
                pending_nxt[c] = 8'h00;
            end
            if (expired && cur == CH_W'(c)) begin
                pending_nxt[c] = pending_nxt[c] | snap;
            end
            if (accept && evt_ch == CH_W'(c)) begin
                pending_nxt[c] = pending_nxt[c] | evt_irq;
            end
        end
    end

    // Pending register file update; reset discards all queued bits.
    // NOTE: this is a small flop array, not a RAM, so clearing it in reset is intended; a RAM macro would not be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pending[c] <= 8'h00;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pending[c] <= pending_nxt[c];
            end
        end
    end

    // Handshake FSM with all outputs registered from the next-state decision.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            last         <= CH_W'(NUM_CH - 1);
            snap         <= 8'h00;
            cnt          <= '0;
            ack_o        <= '0;
            irq_o        <= '0;
            done_valid   <= 1'b0;
            done_ch      <= '0;
            done_timeout <= 1'b0;
            busy         <= 1'b0;
            evt_ready    <= 1'b0;
        end else begin
            evt_ready  <= 1'b1;
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state                        <= WAIT;
                        cur                          <= sel_ch;
                        snap                         <= pending[sel_ch];
                        cnt                          <= '0;
                        ack_o                        <= '0;
                        ack_o[sel_ch]                <= 1'b1;
                        irq_o                        <= '0;
                        irq_o[{sel_ch, 3'b000} +: 8] <= pending[sel_ch];
                        busy                         <= 1'b1;
                    end
                end
                WAIT: begin
                    if (granted || expired) begin
                        state        <= DONE;
                        done_valid   <= 1'b1;
                        done_ch      <= cur;
                        done_timeout <= !granted;
                        ack_o        <= '0;
                        irq_o        <= '0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    last  <= cur;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack_o <= '0;
                    irq_o <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
